// File: rtl/suite_pkg.sv
// Shared types for the video timing meter: FSM states, sync polarity constants and the measurement record.
package suite_pkg;

  localparam int CW_DEFAULT = 12;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } meter_state_t;

  typedef struct packed {
    logic [CW_DEFAULT-1:0] h_active;
    logic [CW_DEFAULT-1:0] h_total;
    logic [CW_DEFAULT-1:0] v_active;
    logic [CW_DEFAULT-1:0] v_total;
  } meas_t;

endpackage

// File: rtl/sync_edge_det.sv
// Leading-edge detector on a sync input, evaluated only on pixel-enable samples.
// Combinational pulse on the sample that goes active; no backpressure (paced by ce).
module sync_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic sync,
  output logic lead
);

  logic act;
  logic prev_act;

  assign act = (sync == POL);

  // Held "active" through reset so a sync already asserted at release is not taken as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_act <= 1'b1;
    end else if (ce) begin
      prev_act <= act;
    end
  end

  assign lead = ce && act && !prev_act;

endmodule

// File: rtl/video_timing_meter.sv
// Registers the pixel stream by one ce sample and measures line/frame geometry, publishing per-frame results.
// Stream latency 1 ce sample; measurements update on the clk after each v_sync edge; no backpressure.
module video_timing_meter
  import suite_pkg::*;
#(
  parameter int CW            = CW_DEFAULT,
  parameter bit HS_POL        = SYNC_ACTIVE_LOW,
  parameter bit VS_POL        = SYNC_ACTIVE_HIGH,
  parameter int STABLE_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          h_blank,
  input  logic          v_blank,
  input  logic          h_sync,
  input  logic          v_sync,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  output logic          o_ce_pix,
  output logic          o_h_blank,
  output logic          o_v_blank,
  output logic          o_h_sync,
  output logic          o_v_sync,
  output logic [7:0]    o_r,
  output logic [7:0]    o_g,
  output logic [7:0]    o_b,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] v_total,
  output logic          meas_valid,
  output logic          meas_changed
);

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [3:0]    STABLE_MAX = 4'hF;
  localparam logic [3:0]    STABLE_TH  = 4'(STABLE_FRAMES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  logic          h_lead, v_lead;
  logic [CW-1:0] pix_cnt, act_cnt;
  logic [CW-1:0] line_total, line_active;
  logic [CW-1:0] line_cnt, vact_cnt;
  logic          line_has_act;
  logic [CW-1:0] line_total_n, line_active_n, line_cnt_n, vact_cnt_n;
  logic          cnt_sat;
  meas_t         cand, meas;
  meter_state_t  state;
  logic [3:0]    stable_cnt, stable_inc;

  sync_edge_det #(.POL(HS_POL)) u_hs_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_pix),
    .sync  (h_sync),
    .lead  (h_lead)
  );

  sync_edge_det #(.POL(VS_POL)) u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_pix),
    .sync  (v_sync),
    .lead  (v_lead)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      o_ce_pix  <= 1'b0;
      o_h_blank <= 1'b1;
      o_v_blank <= 1'b1;
      o_h_sync  <= 1'b0;
      o_v_sync  <= 1'b0;
      o_r       <= '0;
      o_g       <= '0;
      o_b       <= '0;
    end else begin
      o_ce_pix <= ce_pix;
      if (ce_pix) begin
        o_h_blank <= h_blank;
        o_v_blank <= v_blank;
        o_h_sync  <= h_sync;
        o_v_sync  <= v_sync;
        o_r       <= r;
        o_g       <= g;
        o_b       <= b;
      end
    end
  end

  // Line-end results as they stand after this sample, so a coincident v edge commits the line just closed.
  always_comb begin
    line_total_n  = line_total;
    line_active_n = line_active;
    line_cnt_n    = line_cnt;
    vact_cnt_n    = vact_cnt;
    if (h_lead) begin
      line_total_n  = pix_cnt;
      line_active_n = act_cnt;
      line_cnt_n    = sat_inc(line_cnt);
      if (line_has_act) begin
        vact_cnt_n = sat_inc(vact_cnt);
      end
    end
    cand.h_active = line_active_n;
    cand.h_total  = line_total_n;
    cand.v_active = vact_cnt_n;
    cand.v_total  = line_cnt_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt      <= '0;
      act_cnt      <= '0;
      line_total   <= '0;
      line_active  <= '0;
      line_cnt     <= '0;
      vact_cnt     <= '0;
      line_has_act <= 1'b0;
    end else if (ce_pix) begin
      if (h_lead) begin
        pix_cnt      <= CW'(1);
        act_cnt      <= {{(CW-1){1'b0}}, !h_blank};
        line_has_act <= !h_blank && !v_blank;
      end else begin
        pix_cnt <= sat_inc(pix_cnt);
        if (!h_blank) begin
          act_cnt <= sat_inc(act_cnt);
        end
        if (!h_blank && !v_blank) begin
          line_has_act <= 1'b1;
        end
      end
      line_total  <= line_total_n;
      line_active <= line_active_n;
      if (v_lead) begin
        line_cnt <= '0;
        vact_cnt <= '0;
      end else begin
        line_cnt <= line_cnt_n;
        vact_cnt <= vact_cnt_n;
      end
    end
  end

  assign cnt_sat    = (pix_cnt == CNT_MAX) || (line_cnt == CNT_MAX);
  assign stable_inc = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 4'd1;

  // A saturated counter means the syncs are gone; drop lock but keep the last published values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      meas         <= '0;
      meas_valid   <= 1'b0;
      meas_changed <= 1'b0;
      stable_cnt   <= '0;
    end else begin
      meas_changed <= 1'b0;
      if (cnt_sat) begin
        state      <= IDLE;
        meas_valid <= 1'b0;
        stable_cnt <= '0;
      end else if (v_lead) begin
        case (state)
          IDLE: state <= ARMED;
          default: begin
            state <= MEASURE;
            meas  <= cand;
            if (cand == meas) begin
              stable_cnt <= stable_inc;
              meas_valid <= (stable_inc >= STABLE_TH);
            end else begin
              stable_cnt   <= '0;
              meas_valid   <= 1'b0;
              meas_changed <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign h_active = meas.h_active;
  assign h_total  = meas.h_total;
  assign v_active = meas.v_active;
  assign v_total  = meas.v_total;

endmodule

// File: tb/tb_video_timing_meter.sv
// Self-checking bench for video_timing_meter: raster driver, frame-result scoreboard and stream pass-through checks.
module tb_video_timing_meter;
  import suite_pkg::*;

  localparam int SF = 2;

  typedef struct packed {
    meas_t m;
    logic  valid;
    logic  changed;
  } rec_t;

  typedef struct packed {
    logic       hb, vb, hs, vs;
    logic [7:0] rr, gg, bb;
  } px_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce_pix = 1'b0;
  logic        h_blank = 1'b1, v_blank = 1'b1, h_sync = 1'b1, v_sync = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        o_ce_pix, o_h_blank, o_v_blank, o_h_sync, o_v_sync;
  logic [7:0]  o_r, o_g, o_b;
  logic [11:0] h_active, h_total, v_active, v_total;
  logic        meas_valid, meas_changed;

  int checks = 0;
  int errors = 0;
  int chg_pulses = 0;

  rec_t  exp_q[$];
  rec_t  obs_q[$];
  px_t   px_q[$];
  meas_t mdl_prev;
  int    mdl_stable;

  video_timing_meter #(.STABLE_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .h_blank(h_blank), .v_blank(v_blank), .h_sync(h_sync), .v_sync(v_sync),
    .r(r), .g(g), .b(b),
    .o_ce_pix(o_ce_pix), .o_h_blank(o_h_blank), .o_v_blank(o_v_blank),
    .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .h_active(h_active), .h_total(h_total), .v_active(v_active), .v_total(v_total),
    .meas_valid(meas_valid), .meas_changed(meas_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (meas_changed === 1'b1) chg_pulses++;

  function automatic meas_t mk(input int ha, ht, va, vt);
    meas_t m;
    m.h_active = 12'(ha); m.h_total = 12'(ht); m.v_active = 12'(va); m.v_total = 12'(vt);
    return m;
  endfunction

  function automatic rec_t snapshot();
    rec_t o;
    o.m       = {h_active, h_total, v_active, v_total};
    o.valid   = meas_valid;
    o.changed = meas_changed;
    return o;
  endfunction

  // Reference behaviour of the frame results, one entry per v_sync leading edge.
  task automatic model_reset();
    mdl_prev   = '0;
    mdl_stable = 0;
  endtask

  task automatic expect_arm();
    rec_t e;
    mdl_stable = 0;
    e.m = mdl_prev; e.valid = 1'b0; e.changed = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic expect_commit(input meas_t m);
    rec_t e;
    e.changed = (m != mdl_prev);
    if (e.changed) mdl_stable = 0;
    else if (mdl_stable < 15) mdl_stable++;
    e.valid = !e.changed && (mdl_stable >= SF - 1);
    e.m = m;
    mdl_prev = m;
    exp_q.push_back(e);
  endtask

  task automatic drive_px(input logic ce, hb, vb, hs, vs, input logic [7:0] rr, gg, bb);
    ce_pix = ce; h_blank = hb; v_blank = vb; h_sync = hs; v_sync = vs; r = rr; g = gg; b = bb;
    @(posedge clk);
    #1;
  endtask

  // h_sync (active low) over x in [ha+2, ha+6); v_sync (active high) for two lines from row va+1, column vs_x.
  task automatic drive_raster(input int ha, ht, va, vs_x, n0, n1);
    int x, y, vs_start;
    logic hs_act, vs_act;
    vs_start = (va + 1) * ht + vs_x;
    for (int n = n0; n < n1; n++) begin
      x = n % ht;
      y = n / ht;
      hs_act = (x >= ha + 2) && (x < ha + 6);
      vs_act = (n >= vs_start) && (n < vs_start + 2 * ht);
      drive_px(1'b1, x >= ha, y >= va, !hs_act, vs_act, 8'(x), 8'(y), 8'(n));
      if (n == vs_start) obs_q.push_back(snapshot());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_px(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 8'hFF);
    drive_px(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 8'hFF);
    checks++;
    if ({o_h_blank, o_v_blank, o_h_sync, o_v_sync, o_r, o_g, o_b} !== {4'b1100, 24'd0}) begin
      errors++;
      $display("FAIL reset_stream: got %h want %h", {o_h_blank, o_v_blank, o_h_sync, o_v_sync, o_r, o_g, o_b}, {4'b1100, 24'd0});
    end
    checks++;
    if (o_ce_pix !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", o_ce_pix); end
    reset = 1'b0;
    drive_px(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    checks++;
    if ({h_active, h_total, v_active, v_total} !== 48'd0) begin
      errors++;
      $display("FAIL reset_meas: got %0d/%0d/%0d/%0d want 0/0/0/0", h_active, h_total, v_active, v_total);
    end
    checks++;
    if ({meas_valid, meas_changed} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b changed=%b want 0 0", meas_valid, meas_changed);
    end
    model_reset();
  endtask

  task automatic test_measure();
    rec_t e, o;
    int k = 0;
    expect_arm();
    for (int i = 0; i < 3; i++) expect_commit(mk(320, 392, 8, 12));
    for (int f = 0; f < 4; f++) drive_raster(320, 392, 8, 0, 0, 392 * 12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); k++; checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL measure edge %0d: no v_sync edge observed", k); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL measure edge %0d: got %0d/%0d/%0d/%0d v=%b c=%b want %0d/%0d/%0d/%0d v=%b c=%b", k,
                   o.m.h_active, o.m.h_total, o.m.v_active, o.m.v_total, o.valid, o.changed,
                   e.m.h_active, e.m.h_total, e.m.v_active, e.m.v_total, e.valid, e.changed);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_change();
    rec_t e, o;
    int k = 0;
    int c0 = chg_pulses;
    for (int i = 0; i < 3; i++) expect_commit(mk(320, 400, 8, 12));
    for (int f = 0; f < 3; f++) drive_raster(320, 400, 8, 0, 0, 400 * 12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); k++; checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL change edge %0d: no v_sync edge observed", k); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL change edge %0d: got %0d/%0d/%0d/%0d v=%b c=%b want %0d/%0d/%0d/%0d v=%b c=%b", k,
                   o.m.h_active, o.m.h_total, o.m.v_active, o.m.v_total, o.valid, o.changed,
                   e.m.h_active, e.m.h_total, e.m.v_active, e.m.v_total, e.valid, e.changed);
        end
      end
    end
    obs_q.delete();
    checks++;
    if (chg_pulses - c0 !== 1) begin errors++; $display("FAIL change_pulses: got %0d want 1", chg_pulses - c0); end
  endtask

  task automatic test_saturation();
    rec_t e, o;
    repeat (4000) drive_px(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    checks++;
    if (meas_valid !== 1'b1) begin errors++; $display("FAIL sat_early: got valid=%b want 1", meas_valid); end
    repeat (200) drive_px(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    checks++;
    if ({meas_valid, meas_changed} !== 2'b00) begin
      errors++;
      $display("FAIL sat_flags: got valid=%b changed=%b want 0 0", meas_valid, meas_changed);
    end
    checks++;
    if ({h_active, h_total, v_active, v_total} !== mk(320, 400, 8, 12)) begin
      errors++;
      $display("FAIL sat_hold: got %0d/%0d/%0d/%0d want 320/400/8/12", h_active, h_total, v_active, v_total);
    end
    expect_arm();
    drive_raster(320, 400, 8, 0, 0, 400 * 12);
    e = exp_q.pop_front(); checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL sat_rearm: no v_sync edge observed"); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL sat_rearm: got %0d/%0d/%0d/%0d v=%b c=%b want %0d/%0d/%0d/%0d v=%b c=%b",
                 o.m.h_active, o.m.h_total, o.m.v_active, o.m.v_total, o.valid, o.changed,
                 e.m.h_active, e.m.h_total, e.m.v_active, e.m.v_total, e.valid, e.changed);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_coincident();
    rec_t e, o;
    int k = 0;
    reset = 1'b1;
    drive_px(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    reset = 1'b0;
    model_reset();
    expect_arm();
    for (int i = 0; i < 2; i++) expect_commit(mk(32, 40, 24, 28));
    for (int f = 0; f < 3; f++) drive_raster(32, 40, 24, 34, 0, 40 * 28);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); k++; checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL coincident edge %0d: no v_sync edge observed", k); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL coincident edge %0d: got %0d/%0d/%0d/%0d v=%b c=%b want %0d/%0d/%0d/%0d v=%b c=%b", k,
                   o.m.h_active, o.m.h_total, o.m.v_active, o.m.v_total, o.valid, o.changed,
                   e.m.h_active, e.m.h_total, e.m.v_active, e.m.v_total, e.valid, e.changed);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    rec_t e, o;
    int k = 0;
    drive_raster(32, 40, 24, 0, 0, 500);
    reset = 1'b1;
    drive_px(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2, 8'd3);
    reset = 1'b0;
    checks++;
    if ({o_ce_pix, o_h_blank, o_v_blank, o_h_sync, o_v_sync, o_r, o_g, o_b} !== {5'b01100, 24'd0}) begin
      errors++;
      $display("FAIL midreset_stream: got %h want %h",
               {o_ce_pix, o_h_blank, o_v_blank, o_h_sync, o_v_sync, o_r, o_g, o_b}, {5'b01100, 24'd0});
    end
    checks++;
    if ({h_active, h_total, v_active, v_total, meas_valid, meas_changed} !== 50'd0) begin
      errors++;
      $display("FAIL midreset_meas: got %0d/%0d/%0d/%0d v=%b c=%b want all 0",
               h_active, h_total, v_active, v_total, meas_valid, meas_changed);
    end
    model_reset();
    expect_arm();
    for (int i = 0; i < 2; i++) expect_commit(mk(32, 40, 24, 28));
    drive_raster(32, 40, 24, 0, 500, 40 * 28);
    for (int f = 0; f < 2; f++) drive_raster(32, 40, 24, 0, 0, 40 * 28);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); k++; checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midreset edge %0d: no v_sync edge observed", k); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL midreset edge %0d: got %0d/%0d/%0d/%0d v=%b c=%b want %0d/%0d/%0d/%0d v=%b c=%b", k,
                   o.m.h_active, o.m.h_total, o.m.v_active, o.m.v_total, o.valid, o.changed,
                   e.m.h_active, e.m.h_total, e.m.v_active, e.m.v_total, e.valid, e.changed);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_pass_through();
    px_t  p, held;
    logic ce;
    logic have_held = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ce = (i % 4 == 0);
      p = {1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      if (ce) px_q.push_back(p);
      drive_px(ce, p.hb, p.vb, p.hs, p.vs, p.rr, p.gg, p.bb);
      checks++;
      if (o_ce_pix !== ce) begin errors++; $display("FAIL pass_ce cycle %0d: got %b want %b", i, o_ce_pix, ce); end
      if (o_ce_pix === 1'b1 && px_q.size() > 0) begin
        held = px_q.pop_front();
        have_held = 1'b1;
      end
      if (have_held) begin
        checks++;
        if ({o_h_blank, o_v_blank, o_h_sync, o_v_sync, o_r, o_g, o_b} !== held) begin
          errors++;
          $display("FAIL pass_data cycle %0d: got %h want %h", i,
                   {o_h_blank, o_v_blank, o_h_sync, o_v_sync, o_r, o_g, o_b}, held);
        end
      end
    end
    checks++;
    if (px_q.size() != 0) begin errors++; $display("FAIL pass_drain: got %0d samples pending want 0", px_q.size()); end
  endtask

  initial begin
    test_reset();
    test_measure();
    test_change();
    test_saturation();
    test_coincident();
    test_reset_mid_frame();
    test_pass_through();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
